// File: rtl/cac_enc_9_seq_pkg.sv
// Shared link constants, FSM state encodings and weight widths for the 9-wire FNS CAC encoder.
// Weight/data widths come from the Fibo link macros; defaults below apply when they are not predefined.
`ifndef BLEN_09
`define BLEN_09 6
`endif
`ifndef FNSLEN_03
`define FNSLEN_03 2
`endif
`ifndef FNSLEN_04
`define FNSLEN_04 2
`endif
`ifndef FNSLEN_05
`define FNSLEN_05 3
`endif
`ifndef FNSLEN_06
`define FNSLEN_06 4
`endif
`ifndef FNSLEN_07
`define FNSLEN_07 4
`endif
`ifndef FNSLEN_08
`define FNSLEN_08 5
`endif
`ifndef FNSLEN_09
`define FNSLEN_09 6
`endif
`ifndef CACENC_NBITS_09
`define CACENC_NBITS_09 9
`endif
`ifndef CACENC_IDLE
`define CACENC_IDLE 2'd0
`endif
`ifndef CACENC_CALC
`define CACENC_CALC 2'd1
`endif
`ifndef CACENC_DONE
`define CACENC_DONE 2'd2
`endif

package cac_enc_9_seq_pkg;

  localparam int BLEN     = `BLEN_09;
  localparam int FL03     = `FNSLEN_03;
  localparam int FL04     = `FNSLEN_04;
  localparam int FL05     = `FNSLEN_05;
  localparam int FL06     = `FNSLEN_06;
  localparam int FL07     = `FNSLEN_07;
  localparam int FL08     = `FNSLEN_08;
  localparam int FL09     = `FNSLEN_09;
  localparam int NBITS_09 = `CACENC_NBITS_09;

  // One extra bit over the wider operand keeps the compare unsigned and overflow-free.
  localparam int CMPW = ((BLEN > FL09) ? BLEN : FL09) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = `CACENC_IDLE,
    ST_CALC = `CACENC_CALC,
    ST_DONE = `CACENC_DONE
  } state_e;

endpackage

// File: rtl/cac_enc_step.sv
// One greedy FNS step: emit a 1 and subtract the weight when the remainder covers it.
module cac_enc_step
  import cac_enc_9_seq_pkg::*;
(
  input  logic [BLEN-1:0] rem_i,
  input  logic [FL09-1:0] weight_i,
  output logic            bit_o,
  output logic [BLEN-1:0] rem_next_o
);

  logic [CMPW-1:0] rem_ext;
  logic [CMPW-1:0] w_ext;

  always_comb begin
    rem_ext = CMPW'(rem_i);
    w_ext   = CMPW'(weight_i);
    bit_o   = (rem_ext >= w_ext);
    // When the bit is set the weight fits in the remainder, so truncation is lossless.
    rem_next_o = bit_o ? (rem_i - BLEN'(weight_i)) : rem_i;
  end

endmodule

// File: rtl/cac_enc_9_seq.sv
// Iterative 9-wire FNS CAC encoder: one compare-subtract step per cycle, MSB first, valid/ready both sides.
// Optional range/residual error flag (output err) is built when CACENC_RANGE_CHK_EN is defined.
module cac_enc_9_seq
  import cac_enc_9_seq_pkg::*;
#(
  parameter int NBITS = 9,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLEN-1:0]  datain,
  input  logic [FL03-1:0]  FNS03,
  input  logic [FL04-1:0]  FNS04,
  input  logic [FL05-1:0]  FNS05,
  input  logic [FL06-1:0]  FNS06,
  input  logic [FL07-1:0]  FNS07,
  input  logic [FL08-1:0]  FNS08,
  input  logic [FL09-1:0]  FNS09,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] codeout
`ifdef CACENC_RANGE_CHK_EN
  ,
  output logic             err
`endif
);

  state_e            state_q, state_d;
  logic [CNTW-1:0]   k_q, k_d;
  logic [BLEN-1:0]   rem_q, rem_d;
  logic [NBITS-1:0]  code_q, code_d;
  logic              in_ready_q, in_ready_d;
  logic [FL09-1:0]   w_q   [2:NBITS-1];
  logic [FL09-1:0]   w_d   [2:NBITS-1];
  logic [FL09-1:0]   fns_ext [2:NBITS-1];
  logic [FL09-1:0]   w_sel;
  logic              step_bit;
  logic [BLEN-1:0]   step_rem;

  assign fns_ext[2] = FL09'(FNS03);
  assign fns_ext[3] = FL09'(FNS04);
  assign fns_ext[4] = FL09'(FNS05);
  assign fns_ext[5] = FL09'(FNS06);
  assign fns_ext[6] = FL09'(FNS07);
  assign fns_ext[7] = FL09'(FNS08);
  assign fns_ext[8] = FL09'(FNS09);

  // Bits 0 and 1 always weigh 1; higher bits use the weights captured at accept.
  always_comb begin
    w_sel = FL09'(1);
    for (int i = 2; i < NBITS; i++) begin
      if (k_q == CNTW'(i)) w_sel = w_q[i];
    end
  end

  cac_enc_step u_step (
    .rem_i      (rem_q),
    .weight_i   (w_sel),
    .bit_o      (step_bit),
    .rem_next_o (step_rem)
  );

`ifdef CACENC_RANGE_CHK_EN
  localparam int LW = FL09 + 1;
  logic          err_q, err_d;
  logic [LW-1:0] lim;
  logic          over_lim;

  // Largest legal value is FNS09 + FNS08 - 1.
  assign lim      = LW'(FNS09) + LW'(FNS08) - LW'(1);
  assign over_lim = (LW'(datain) > lim);
  assign err      = err_q;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rem_d   = rem_q;
    code_d  = code_q;
    w_d     = w_q;
`ifdef CACENC_RANGE_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          rem_d   = datain;
          w_d     = fns_ext;
          code_d  = '0;
          k_d     = CNTW'(NBITS - 1);
          state_d = ST_CALC;
`ifdef CACENC_RANGE_CHK_EN
          err_d   = over_lim;
`endif
        end
      end
      ST_CALC: begin
        code_d[k_q] = step_bit;
        rem_d       = step_rem;
        if (k_q == '0) begin
          state_d = ST_DONE;
`ifdef CACENC_RANGE_CHK_EN
          if (step_rem != '0) err_d = 1'b1;
`endif
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered so in_ready stays low through reset and rises one cycle after release.
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      rem_q      <= '0;
      code_q     <= '0;
      in_ready_q <= 1'b0;
      for (int i = 2; i < NBITS; i++) w_q[i] <= '0;
`ifdef CACENC_RANGE_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      rem_q      <= rem_d;
      code_q     <= code_d;
      in_ready_q <= in_ready_d;
      w_q        <= w_d;
`ifdef CACENC_RANGE_CHK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == ST_DONE);
  assign codeout   = code_q;

endmodule

// File: tb/tb_cac_enc_9_seq.sv
// Randomized self-checking bench for cac_enc_9_seq against a greedy FNS reference model.
module tb_cac_enc_9_seq;
  import cac_enc_9_seq_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BLEN-1:0] datain;
  logic [FL03-1:0] FNS03;
  logic [FL04-1:0] FNS04;
  logic [FL05-1:0] FNS05;
  logic [FL06-1:0] FNS06;
  logic [FL07-1:0] FNS07;
  logic [FL08-1:0] FNS08;
  logic [FL09-1:0] FNS09;
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      codeout;
`ifdef CACENC_RANGE_CHK_EN
  logic            err;
`endif

  int checks = 0;
  int errors = 0;
  int wt [9];

  always #5 clk = ~clk;

  cac_enc_9_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .FNS03     (FNS03),
    .FNS04     (FNS04),
    .FNS05     (FNS05),
    .FNS06     (FNS06),
    .FNS07     (FNS07),
    .FNS08     (FNS08),
    .FNS09     (FNS09),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeout   (codeout)
`ifdef CACENC_RANGE_CHK_EN
    ,
    .err       (err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic std_weights();
    wt = '{1, 1, 2, 3, 5, 8, 13, 21, 34};
  endtask

  task automatic rand_weights();
    wt[0] = 1;
    wt[1] = 1;
    wt[2] = $urandom_range(0, 3);
    wt[3] = $urandom_range(0, 3);
    wt[4] = $urandom_range(0, 7);
    wt[5] = $urandom_range(0, 15);
    wt[6] = $urandom_range(0, 15);
    wt[7] = $urandom_range(0, 31);
    wt[8] = $urandom_range(0, 63);
  endtask

  task automatic drive_weights();
    FNS03 = FL03'(wt[2]);
    FNS04 = FL04'(wt[3]);
    FNS05 = FL05'(wt[4]);
    FNS06 = FL06'(wt[5]);
    FNS07 = FL07'(wt[6]);
    FNS08 = FL08'(wt[7]);
    FNS09 = FL09'(wt[8]);
  endtask

  task automatic scramble_weights();
    FNS03 = FL03'($urandom);
    FNS04 = FL04'($urandom);
    FNS05 = FL05'($urandom);
    FNS06 = FL06'($urandom);
    FNS07 = FL07'($urandom);
    FNS08 = FL08'($urandom);
    FNS09 = FL09'($urandom);
  endtask

  // Greedy FNS encoding on plain integers, largest weight first.
  function automatic int model_code(input int d, output int resid);
    int r;
    int c;
    int w;
    r = d;
    c = 0;
    for (int k = 8; k >= 0; k--) begin
      w = wt[k];
      if (r >= w) begin
        c = c | (1 << k);
        r = r - w;
      end
    end
    resid = r;
    return c;
  endfunction

  task automatic send(input int d, input int stall, input bit std_w);
    int n;
    int exp_code;
    int resid;
    int sum;
    int lim;
    bit exp_err;
    exp_code  = model_code(d, resid);
    lim       = (wt[8] + wt[7] - 1) & 127;
    exp_err   = (d > lim) || (resid != 0);
    out_ready = (stall == 0);
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    datain = BLEN'(d);
    drive_weights();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    datain   = BLEN'($urandom);
    scramble_weights();
    check("busy_ready", 32'(in_ready), 32'd0);
    n = 1;
    while (out_valid !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'd10);
    check("codeout", 32'(codeout), 32'(exp_code));
    $display("txn data=%0d stall=%0d code=%b expected=%b", d, stall, codeout, 9'(exp_code));
`ifdef CACENC_RANGE_CHK_EN
    check("err", 32'(err), 32'(exp_err));
`endif
    if (std_w && d <= 54) begin
      sum = 0;
      for (int k = 0; k < 9; k++) if (codeout[k]) sum += wt[k];
      check("decode", 32'(sum), 32'(d));
    end
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'b1;
        datain   = BLEN'($urandom);
        @(posedge clk); #1;
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_code", 32'(codeout), 32'(exp_code));
        check("stall_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    check("release_ready", 32'(in_ready), 32'd1);
    check("release_valid", 32'(out_valid), 32'd0);
    check("hold_code", 32'(codeout), 32'(exp_code));
    @(posedge clk); #1;
    check("idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    datain    = '0;
    std_weights();
    drive_weights();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_codeout", 32'(codeout), 32'd0);
`ifdef CACENC_RANGE_CHK_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    send(0, 0, 1'b1);
    send(54, 0, 1'b1);
    send(33, 0, 1'b1);
    send(1, 5, 1'b1);
    send(55, 0, 1'b1);
    send(54, 3, 1'b1);

    // Abort a word at CALC step 4 with a mid-flight reset.
    datain   = BLEN'(54);
    drive_weights();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_codeout", 32'(codeout), 32'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_output", 32'(seen), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    send(33, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      if (i < 25) std_weights();
      else rand_weights();
      send($urandom_range(0, 63), $urandom_range(0, 3), (i < 25));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
